hazard_ctrl: RTL and testbench

- Drives the stall and clear controls into the ID/EX and IF/ID pipeline registers, and the matching PC-hold signal.
- Reads the register-address and control fields that come back out of those registers: source/destination registers, memory-read flag and register-write enable.
- Produces EX-stage forwarding selects.
- Sequences multi-cycle data-memory waits with a timeout. Sits beside the five-stage datapath in the CPU top level.

---
 rtl/hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage datapath.
//
// Generates the hold/flush controls for the PC, IF/ID, ID/EX and EX/MEM+MEM/WB
// registers. It also generates the EX-stage operand forwarding selects. It
// sequences multi-cycle data-memory accesses with a timeout watchdog.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-low reset
//   id_*               source fields and branch outcome of the ID instruction
//   ex_*               fields read back from the ID/EX register output
//   mem_*, dmem_ready  MEM-stage destination/write-enable, access, memory ready
//   wb_*               WB-stage destination/write-enable
//   stall_*, clear_*   register hold / flush controls (1 = hold / flush)
//   fwd_a, fwd_b       EX operand select: 00 reg file, 10 MEM result, 01 WB result
//   mem_timeout        sticky flag: data memory exceeded WAIT_MAX wait cycles
//   stall_cnt          saturating count of cycles spent with the PC held
module hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch_taken,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_dst,
  input  logic             ex_mem_r,
  input  logic             ex_w_reg_ena,
  input  logic [4:0]       mem_dst,
  input  logic             mem_w_reg_ena,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic [4:0]       wb_dst,
  input  logic             wb_w_reg_ena,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             clear_ifid,
  output logic             stall_idex,
  output logic             clear_idex,
  output logic             stall_exmem,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WCNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t            state;
  logic [WCNT_W-1:0] wait_cnt;

  logic memfreeze;
  logic loaduse;
  logic rt_hit;

  // ex_dst / ex_w_reg_ena are reserved for ID-stage branch-compare forwarding.
  // They are wired in but do not affect any output yet.
  logic unused_reserved;
  assign unused_reserved = ^{ex_dst, ex_w_reg_ena};

  // The RUN-state term covers the first wait cycle before the FSM has moved
  // to WAIT. In WAIT, a ready memory releases the freeze in the same cycle,
  // so the pipeline advances on the completing edge.
  always_comb begin
    memfreeze = 1'b0;
    unique case (state)
      ST_RUN:  memfreeze = mem_access & ~dmem_ready;
      ST_WAIT: memfreeze = ~dmem_ready;
      ST_ERR:  memfreeze = 1'b1;
      default: memfreeze = 1'b1;
    endcase
  end

  always_comb begin
    rt_hit  = id_uses_rt & (ex_rt == id_rt);
    loaduse = ex_mem_r & (ex_rt != 5'd0) & ((ex_rt == id_rs) | rt_hit);
  end

  // The outputs follow a fixed priority: freeze, then load-use, then branch.
  // A load-use stall holds IF/ID with no flush, so a taken branch in ID is
  // re-evaluated on the next cycle instead of being lost.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    clear_ifid  = 1'b0;
    stall_idex  = 1'b0;
    clear_idex  = 1'b0;
    stall_exmem = 1'b0;
    if (!rst) begin
      clear_ifid = 1'b1;
      clear_idex = 1'b1;
    end else if (memfreeze) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
    end else if (loaduse) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      clear_idex = 1'b1;
    end else if (id_branch_taken) begin
      clear_ifid = 1'b1;
    end
  end

  // Forwarding ignores stalls. The younger MEM result wins over WB.
  // Register 0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst) begin
      if (mem_w_reg_ena && mem_dst != 5'd0 && mem_dst == ex_rs)
        fwd_a = 2'b10;
      else if (wb_w_reg_ena && wb_dst != 5'd0 && wb_dst == ex_rs)
        fwd_a = 2'b01;

      if (mem_w_reg_ena && mem_dst != 5'd0 && mem_dst == ex_rt)
        fwd_b = 2'b10;
      else if (wb_w_reg_ena && wb_dst != 5'd0 && wb_dst == ex_rt)
        fwd_b = 2'b01;
    end
  end

  // wait_cnt counts freeze cycles of the current access. It is loaded with 1
  // on entry to WAIT because the RUN cycle that saw ~dmem_ready already
  // stalled. As a result, the ERR transition lands exactly on freeze cycle
  // WAIT_MAX.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (stall_pc && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);

      unique case (state)
        ST_RUN: begin
          if (mem_access && !dmem_ready) begin
            state    <= ST_WAIT;
            wait_cnt <= WCNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (dmem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WCNT_W'(WAIT_MAX - 1)) begin
            state       <= ST_ERR;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        ST_ERR: begin
          mem_timeout <= 1'b1;
        end
        default: begin
          state <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (WAIT_MAX=4, CNT_W=16).
// The stimulus process drives one vector per cycle just after the clock edge
// and queues its hand-computed expected outputs. The monitor pops on the
// falling edge and compares.
// ctrl vector order: {stall_pc, stall_ifid, clear_ifid, stall_idex, clear_idex, stall_exmem}
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rt, id_branch_taken;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic        ex_mem_r, ex_w_reg_ena;
  logic [4:0]  mem_dst;
  logic        mem_w_reg_ena, mem_access, dmem_ready;
  logic [4:0]  wb_dst;
  logic        wb_w_reg_ena;
  logic        stall_pc, stall_ifid, clear_ifid, stall_idex, clear_idex, stall_exmem;
  logic [1:0]  fwd_a, fwd_b;
  logic        mem_timeout;
  logic [15:0] stall_cnt;

  hazard_ctrl #(.WAIT_MAX(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_branch_taken(id_branch_taken),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_mem_r(ex_mem_r), .ex_w_reg_ena(ex_w_reg_ena),
    .mem_dst(mem_dst), .mem_w_reg_ena(mem_w_reg_ena),
    .mem_access(mem_access), .dmem_ready(dmem_ready),
    .wb_dst(wb_dst), .wb_w_reg_ena(wb_w_reg_ena),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .clear_ifid(clear_ifid),
    .stall_idex(stall_idex), .clear_idex(clear_idex), .stall_exmem(stall_exmem),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  ctrl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        to;
    logic [15:0] cnt;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [5:0] C_IDLE   = 6'b000000;
  localparam logic [5:0] C_RST    = 6'b001010;
  localparam logic [5:0] C_LDUSE  = 6'b110010;
  localparam logic [5:0] C_BRANCH = 6'b001000;
  localparam logic [5:0] C_FREEZE = 6'b110101;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: compares one queued expectation per cycle, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".ctrl"}, 32'({stall_pc, stall_ifid, clear_ifid,
                                  stall_idex, clear_idex, stall_exmem}), 32'(e.ctrl));
        chk({e.nm, ".fwd_a"}, 32'(fwd_a), 32'(e.fa));
        chk({e.nm, ".fwd_b"}, 32'(fwd_b), 32'(e.fb));
        chk({e.nm, ".mem_timeout"}, 32'(mem_timeout), 32'(e.to));
        chk({e.nm, ".stall_cnt"}, 32'(stall_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic idle();
    rst = 1'b1;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_branch_taken = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_dst = 5'd0; ex_mem_r = 1'b0; ex_w_reg_ena = 1'b0;
    mem_dst = 5'd0; mem_w_reg_ena = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
    wb_dst = 5'd0; wb_w_reg_ena = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_out(input logic [5:0] c, input logic [1:0] fa, input logic [1:0] fb,
                            input logic to, input logic [15:0] cnt, input string nm);
    exp_t e;
    e.ctrl = c; e.fa = fa; e.fb = fb; e.to = to; e.cnt = cnt; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic set_loaduse();
    ex_mem_r = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    // Reset: outputs are forced even with a live load-use and forwarding match.
    next(); rst = 1'b0; set_loaduse(); ex_rs = 5'd7; mem_dst = 5'd7; mem_w_reg_ena = 1'b1;
    expect_out(C_RST, 2'b00, 2'b00, 1'b0, 16'd0, "reset");

    // Load-use: exactly one bubble.
    next(); set_loaduse();
    expect_out(C_LDUSE, 2'b00, 2'b00, 1'b0, 16'd0, "loaduse");
    next();
    expect_out(C_IDLE, 2'b00, 2'b00, 1'b0, 16'd1, "after_loaduse");

    // No false hazards.
    next(); ex_mem_r = 1'b1;
    expect_out(C_IDLE, 2'b00, 2'b00, 1'b0, 16'd1, "r0_no_hazard");
    next(); ex_mem_r = 1'b1; ex_rt = 5'd6; id_rt = 5'd6; id_rs = 5'd1;
    expect_out(C_IDLE, 2'b00, 2'b00, 1'b0, 16'd1, "rt_unused");
    next(); ex_mem_r = 1'b1; ex_rt = 5'd6; id_rt = 5'd6; id_rs = 5'd1; id_uses_rt = 1'b1;
    expect_out(C_LDUSE, 2'b00, 2'b00, 1'b0, 16'd1, "loaduse_rt");

    // Forwarding.
    next(); ex_rs = 5'd7; ex_rt = 5'd3; mem_dst = 5'd7; wb_dst = 5'd7;
    mem_w_reg_ena = 1'b1; wb_w_reg_ena = 1'b1;
    expect_out(C_IDLE, 2'b10, 2'b00, 1'b0, 16'd2, "fwd_mem_prio");
    next(); ex_rs = 5'd7; ex_rt = 5'd3; mem_dst = 5'd7; wb_dst = 5'd7; wb_w_reg_ena = 1'b1;
    expect_out(C_IDLE, 2'b01, 2'b00, 1'b0, 16'd2, "fwd_wb");
    next(); mem_w_reg_ena = 1'b1; wb_w_reg_ena = 1'b1;
    expect_out(C_IDLE, 2'b00, 2'b00, 1'b0, 16'd2, "fwd_r0");
    next(); ex_rs = 5'd4; ex_rt = 5'd4; mem_dst = 5'd4; wb_dst = 5'd4; wb_w_reg_ena = 1'b1;
    expect_out(C_IDLE, 2'b01, 2'b01, 1'b0, 16'd2, "fwd_b_wb");

    // Branch alone flushes IF/ID only.
    next(); id_branch_taken = 1'b1;
    expect_out(C_BRANCH, 2'b00, 2'b00, 1'b0, 16'd2, "branch");

    // Memory wait of 3 cycles with a branch held in ID.
    for (int unsigned i = 0; i < 3; i++) begin
      next(); mem_access = 1'b1; dmem_ready = 1'b0; id_branch_taken = 1'b1;
      expect_out(C_FREEZE, 2'b00, 2'b00, 1'b0, 16'(2 + i), "mem_wait");
    end
    next(); mem_access = 1'b1; dmem_ready = 1'b1; id_branch_taken = 1'b1;
    expect_out(C_BRANCH, 2'b00, 2'b00, 1'b0, 16'd5, "mem_done");
    next();
    expect_out(C_IDLE, 2'b00, 2'b00, 1'b0, 16'd5, "back_in_run");

    // Priority.
    next(); set_loaduse(); id_branch_taken = 1'b1;
    expect_out(C_LDUSE, 2'b00, 2'b00, 1'b0, 16'd5, "prio_lu_branch");
    next(); set_loaduse(); id_branch_taken = 1'b1; mem_access = 1'b1; dmem_ready = 1'b0;
    expect_out(C_FREEZE, 2'b00, 2'b00, 1'b0, 16'd6, "prio_freeze");

    // Timeout: this access already used 1 freeze cycle, and ERR follows the 4th.
    for (int unsigned i = 0; i < 3; i++) begin
      next(); mem_access = 1'b1; dmem_ready = 1'b0;
      expect_out(C_FREEZE, 2'b00, 2'b00, 1'b0, 16'(7 + i), "timeout_wait");
    end
    for (int unsigned i = 0; i < 2; i++) begin
      next();
      expect_out(C_FREEZE, 2'b00, 2'b00, 1'b1, 16'(10 + i), "err_hold");
    end
    next(); rst = 1'b0;
    expect_out(C_RST, 2'b00, 2'b00, 1'b1, 16'd12, "err_reset");
    next();
    expect_out(C_IDLE, 2'b00, 2'b00, 1'b0, 16'd0, "post_reset");
    next(); mem_access = 1'b1; dmem_ready = 1'b1;
    expect_out(C_IDLE, 2'b00, 2'b00, 1'b0, 16'd0, "mem_ready_now");

    for (int unsigned i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
